// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type and slice width for the sequential CLA adder.
package cla_seq_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla.sv
// cla: 4-bit carry-lookahead adder slice.
module cla
    import cla_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    logic [SLICE_W-1:0] g, p;
    logic [SLICE_W:1]   c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ {c[3:1], cin};
    assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder sequenced one nibble per cycle through a single cla slice.
// Optional subtract mode enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;

    state_t             state, next;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   op_a, op_b, b_in;
    logic               carry, c_in, last;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;

`ifdef CLA_SEQ_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    cla u_cla (
        .a    (op_a[idx*SLICE_W +: SLICE_W]),
        .b    (op_b[idx*SLICE_W +: SLICE_W]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign last = idx == IW'(NSLICE - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : next;

    always_comb begin
        next = state;
        next = state == IDLE ? (start ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= a;
            op_b  <= b_in;
            carry <= c_in;
            sum   <= '0;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*SLICE_W +: SLICE_W] <= s_sum;
            carry <= s_cout;
            if (last) cout <= s_cout;
            else idx <= idx + 1'b1;
        end
    end
endmodule
